// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, stall generation and bubble insertion.
// Optional stall-cycle counter enabled by defining ID_EX_STALL_COUNTER_EN.
module id_ex_hazard_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] ID_Instruction,
  input  logic [DATA_WIDTH-1:0] ID_ReadData1,
  input  logic [DATA_WIDTH-1:0] ID_ReadData2,
  input  logic [DATA_WIDTH-1:0] ID_Immediate,
  input  logic [DATA_WIDTH-1:0] ID_PCPlus4,
  input  logic [DATA_WIDTH-1:0] ID_RegisterDestination,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_MemWrite,
  input  logic [CTRL_WIDTH-1:0] ID_Control,
  input  logic                  BranchFlush,
  output logic [DATA_WIDTH-1:0] EX_Instruction,
  output logic [DATA_WIDTH-1:0] EX_ReadData1,
  output logic [DATA_WIDTH-1:0] EX_ReadData2,
  output logic [DATA_WIDTH-1:0] EX_Immediate,
  output logic [DATA_WIDTH-1:0] EX_PCPlus4,
  output logic [DATA_WIDTH-1:0] EX_RegisterDestination,
  output logic                  EX_RegWrite,
  output logic                  EX_MemRead,
  output logic                  EX_MemWrite,
  output logic [CTRL_WIDTH-1:0] EX_Control,
  output logic                  EX_Valid,
  output logic                  Stall,
  output logic [31:0]           StallCount
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned CNT_W = 32;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
  localparam logic [OP_W-1:0] OP_SH    = 6'b101001;

  logic [OP_W-1:0]  opcode;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             rt_is_src;
  logic             dest_match;
  logic             load_use;

  // Hazard detection: a valid load in EX whose nonzero destination feeds an ID source
  always_comb begin
    opcode    = ID_Instruction[31:26];
    rs        = ID_Instruction[25:21];
    rt        = ID_Instruction[20:16];
    rt_is_src = 1'b0;
    case (opcode)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_SB, OP_SH: rt_is_src = 1'b1;
      default:                                       rt_is_src = 1'b0;
    endcase
    dest_match = (EX_RegisterDestination == DATA_WIDTH'(rs)) ||
                 (rt_is_src && (EX_RegisterDestination == DATA_WIDTH'(rt)));
    load_use   = EX_MemRead && EX_Valid && (EX_RegisterDestination != '0) && dest_match;
    Stall      = load_use && !BranchFlush;
  end

  // Pipeline register; reset, flush and load-use all produce an all-zero bubble
  always_ff @(posedge Clk) begin
    if (!Reset || BranchFlush || load_use) begin
      EX_Instruction         <= '0;
      EX_ReadData1           <= '0;
      EX_ReadData2           <= '0;
      EX_Immediate           <= '0;
      EX_PCPlus4             <= '0;
      EX_RegisterDestination <= '0;
      EX_RegWrite            <= 1'b0;
      EX_MemRead             <= 1'b0;
      EX_MemWrite            <= 1'b0;
      EX_Control             <= '0;
      EX_Valid               <= 1'b0;
    end else begin
      EX_Instruction         <= ID_Instruction;
      EX_ReadData1           <= ID_ReadData1;
      EX_ReadData2           <= ID_ReadData2;
      EX_Immediate           <= ID_Immediate;
      EX_PCPlus4             <= ID_PCPlus4;
      EX_RegisterDestination <= ID_RegisterDestination;
      EX_RegWrite            <= ID_RegWrite;
      EX_MemRead             <= ID_MemRead;
      EX_MemWrite            <= ID_MemWrite;
      EX_Control             <= ID_Control;
      EX_Valid               <= 1'b1;
    end
  end

`ifdef ID_EX_STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_count_q;

  // Saturating count of stall cycles
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stall_count_q <= '0;
    end else if (Stall && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign StallCount = stall_count_q;
`else
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed self-checking bench for id_ex_hazard_stage (hazard detection, bubbles, flush, reset, counter).
module tb_id_ex_hazard_stage;

`ifdef ID_EX_STALL_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [31:0] LW8      = 32'h8D28_0000; // lw  $8,0($9)
  localparam logic [31:0] LW0      = 32'h8D20_0000; // lw  $0,0($9)
  localparam logic [31:0] LW9_8    = 32'h8D09_0000; // lw  $9,0($8)
  localparam logic [31:0] ADD10_8  = 32'h010B_5020; // add $10,$8,$11
  localparam logic [31:0] ADD10_9  = 32'h012B_5020; // add $10,$9,$11
  localparam logic [31:0] ADD10_0  = 32'h0000_5020; // add $10,$0,$0
  localparam logic [31:0] ADD8_9   = 32'h0129_4020; // add $8,$9,$9
  localparam logic [31:0] ADD10_88 = 32'h0108_5020; // add $10,$8,$8

  logic        Clk;
  logic        Reset;
  logic [31:0] ID_Instruction, ID_ReadData1, ID_ReadData2, ID_Immediate, ID_PCPlus4;
  logic [31:0] ID_RegisterDestination;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite;
  logic [15:0] ID_Control;
  logic        BranchFlush;
  logic [31:0] EX_Instruction, EX_ReadData1, EX_ReadData2, EX_Immediate, EX_PCPlus4;
  logic [31:0] EX_RegisterDestination;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite;
  logic [15:0] EX_Control;
  logic        EX_Valid;
  logic        Stall;
  logic [31:0] StallCount;

  int checks = 0;
  int errors = 0;
  int n_stall = 0;

  id_ex_hazard_stage dut (
    .Clk(Clk), .Reset(Reset),
    .ID_Instruction(ID_Instruction), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Immediate(ID_Immediate), .ID_PCPlus4(ID_PCPlus4),
    .ID_RegisterDestination(ID_RegisterDestination),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_Control(ID_Control), .BranchFlush(BranchFlush),
    .EX_Instruction(EX_Instruction), .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
    .EX_Immediate(EX_Immediate), .EX_PCPlus4(EX_PCPlus4),
    .EX_RegisterDestination(EX_RegisterDestination),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_Control(EX_Control), .EX_Valid(EX_Valid), .Stall(Stall), .StallCount(StallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Data fields are derived from the instruction so every field is distinguishable
  task automatic drive_id(input logic [31:0] instr, input logic [31:0] rd,
                          input logic rw, input logic mr, input logic mw);
    ID_Instruction         = instr;
    ID_ReadData1           = instr ^ 32'h1111_1111;
    ID_ReadData2           = instr ^ 32'h2222_2222;
    ID_Immediate           = {16'h0000, instr[15:0]};
    ID_PCPlus4             = instr ^ 32'h0000_4444;
    ID_RegisterDestination = rd;
    ID_RegWrite            = rw;
    ID_MemRead             = mr;
    ID_MemWrite            = mw;
    ID_Control             = instr[31:16] ^ 16'hA5A5;
  endtask

  task automatic check_ex(input string tag, input logic [31:0] instr, input logic [31:0] rd,
                          input logic rw, input logic mr, input logic mw);
    logic [15:0] hi;
    hi = instr[31:16];
    check({tag, "_instr"}, EX_Instruction, instr);
    check({tag, "_rd1"},   EX_ReadData1, instr ^ 32'h1111_1111);
    check({tag, "_rd2"},   EX_ReadData2, instr ^ 32'h2222_2222);
    check({tag, "_imm"},   EX_Immediate, {16'h0000, instr[15:0]});
    check({tag, "_pc4"},   EX_PCPlus4, instr ^ 32'h0000_4444);
    check({tag, "_dest"},  EX_RegisterDestination, rd);
    check({tag, "_ctl3"},  {29'h0, EX_RegWrite, EX_MemRead, EX_MemWrite}, {29'h0, rw, mr, mw});
    check({tag, "_ctrl"},  {16'h0, EX_Control}, {16'h0, hi ^ 16'hA5A5});
    check({tag, "_valid"}, {31'h0, EX_Valid}, 32'h1);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_instr"}, EX_Instruction, 32'h0);
    check({tag, "_data"},  EX_ReadData1 | EX_ReadData2 | EX_Immediate | EX_PCPlus4, 32'h0);
    check({tag, "_dest"},  EX_RegisterDestination, 32'h0);
    check({tag, "_ctl"},   {13'h0, EX_Control, EX_RegWrite, EX_MemRead, EX_MemWrite}, 32'h0);
    check({tag, "_valid"}, {31'h0, EX_Valid}, 32'h0);
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_EN ? 32'(n) : 32'h0;
  endfunction

  // Dependent instruction after lw $8 in EX; stall expected only when rt/rs is a real source
  typedef struct { logic [31:0] instr; logic stall; } dep_t;
  dep_t deps[8];

  initial begin
    deps[0] = '{32'hAD28_0000, 1'b1}; // sw   $8,0($9)
    deps[1] = '{32'h1128_0000, 1'b1}; // beq  $9,$8
    deps[2] = '{32'h1528_0000, 1'b1}; // bne  $9,$8
    deps[3] = '{32'hA128_0000, 1'b1}; // sb   $8,0($9)
    deps[4] = '{32'hA528_0000, 1'b1}; // sh   $8,0($9)
    deps[5] = '{32'h0128_5020, 1'b1}; // add  $10,$9,$8
    deps[6] = '{32'h3528_0005, 1'b0}; // ori  $8,$9,5
    deps[7] = '{32'h2128_0000, 1'b0}; // addi $8,$9,0

    // Reset with all ID inputs high
    Reset = 1'b0;
    BranchFlush = 1'b0;
    ID_Instruction = '1; ID_ReadData1 = '1; ID_ReadData2 = '1; ID_Immediate = '1;
    ID_PCPlus4 = '1; ID_RegisterDestination = '1;
    ID_RegWrite = 1'b1; ID_MemRead = 1'b1; ID_MemWrite = 1'b1; ID_Control = '1;
    tick();
    tick();
    check_bubble("reset");
    check("reset_stall", {31'h0, Stall}, 32'h0);
    check("reset_cnt", StallCount, 32'h0);
    Reset = 1'b1;

    // Load-use on rs
    drive_id(LW8, 32'd8, 1'b1, 1'b1, 1'b0);
    tick();
    check_ex("lw_ex", LW8, 32'd8, 1'b1, 1'b1, 1'b0);
    drive_id(ADD10_8, 32'd10, 1'b1, 1'b0, 1'b0);
    #1;
    check("lu_rs_stall", {31'h0, Stall}, 32'h1);
    tick();
    n_stall++;
    check_bubble("lu_bubble");
    check("lu_after_stall", {31'h0, Stall}, 32'h0);
    tick();
    check_ex("add_ex", ADD10_8, 32'd10, 1'b1, 1'b0, 1'b0);
    check("lu_cnt", StallCount, exp_cnt(n_stall));

    // rt source decoding
    foreach (deps[i]) begin
      drive_id(LW8, 32'd8, 1'b1, 1'b1, 1'b0);
      tick();
      drive_id(deps[i].instr, 32'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check($sformatf("src%0d_stall", i), {31'h0, Stall}, {31'h0, deps[i].stall});
      tick();
      if (deps[i].stall) n_stall++;
      check($sformatf("src%0d_valid", i), {31'h0, EX_Valid}, {31'h0, !deps[i].stall});
      check($sformatf("src%0d_instr", i), EX_Instruction, deps[i].stall ? 32'h0 : deps[i].instr);
    end
    check("src_cnt", StallCount, exp_cnt(n_stall));

    // $0 destination never stalls
    drive_id(LW0, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(ADD10_0, 32'd10, 1'b1, 1'b0, 1'b0);
    #1;
    check("zero_stall", {31'h0, Stall}, 32'h0);
    tick();
    check_ex("zero_add", ADD10_0, 32'd10, 1'b1, 1'b0, 1'b0);

    // Non-load producer never stalls
    drive_id(ADD8_9, 32'd8, 1'b1, 1'b0, 1'b0);
    tick();
    drive_id(ADD10_88, 32'd10, 1'b1, 1'b0, 1'b0);
    #1;
    check("nonload_stall", {31'h0, Stall}, 32'h0);
    tick();
    check("nonload_instr", EX_Instruction, ADD10_88);

    // Back-to-back loads with dependents: one bubble each
    drive_id(LW8, 32'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(LW9_8, 32'd9, 1'b1, 1'b1, 1'b0);
    #1;
    check("b2b_stall1", {31'h0, Stall}, 32'h1);
    tick();
    n_stall++;
    check("b2b_nostall", {31'h0, Stall}, 32'h0);
    tick();
    check_ex("b2b_lw9", LW9_8, 32'd9, 1'b1, 1'b1, 1'b0);
    drive_id(ADD10_9, 32'd10, 1'b1, 1'b0, 1'b0);
    #1;
    check("b2b_stall2", {31'h0, Stall}, 32'h1);
    tick();
    n_stall++;
    check("b2b_bubble", {31'h0, EX_Valid}, 32'h0);
    tick();
    check("b2b_add", EX_Instruction, ADD10_9);
    check("b2b_cnt", StallCount, exp_cnt(n_stall));

    // Flush beats load-use
    drive_id(LW8, 32'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(ADD10_8, 32'd10, 1'b1, 1'b0, 1'b0);
    BranchFlush = 1'b1;
    #1;
    check("flush_stall", {31'h0, Stall}, 32'h0);
    tick();
    check_bubble("flush_lu");
    check("flush_cnt", StallCount, exp_cnt(n_stall));
    // Flush alone on a hazard-free instruction
    tick();
    check_bubble("flush_only");
    BranchFlush = 1'b0;
    tick();
    check("after_flush", EX_Instruction, ADD10_8);

    // Reset during a stall
    drive_id(LW8, 32'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(ADD10_8, 32'd10, 1'b1, 1'b0, 1'b0);
    #1;
    check("rst_mid_stall", {31'h0, Stall}, 32'h1);
    Reset = 1'b0;
    tick();
    n_stall = 0;
    check_bubble("rst_mid");
    check("rst_mid_nostall", {31'h0, Stall}, 32'h0);
    check("rst_mid_cnt", StallCount, 32'h0);
    Reset = 1'b1;

    // Counter saturation
`ifdef ID_EX_STALL_COUNTER_EN
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_q;
`endif
    for (int k = 0; k < 3; k++) begin
      drive_id(LW8, 32'd8, 1'b1, 1'b1, 1'b0);
      tick();
      drive_id(ADD10_8, 32'd10, 1'b1, 1'b0, 1'b0);
      #1;
      check($sformatf("sat%0d_stall", k), {31'h0, Stall}, 32'h1);
      tick();
    end
    check("sat_cnt", StallCount, CNT_EN ? 32'hFFFF_FFFF : 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_stage.md
# id_ex_hazard_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. It captures decoded ID-stage instruction, operands, destination and control each cycle and presents them to the EX stage and to `ForwardingUnit` (`Instruction`, `RegisterDestination`). It detects load-use hazards that forwarding cannot resolve, freezes PC and IF/ID through `Stall`, and inserts a bubble. It also inserts a bubble on branch flush.

## Interface
- `DATA_WIDTH`, 32: width of datapath words (instruction, operands, immediate, PC+4, destination).
- `CTRL_WIDTH`, 16: width of the opaque ALU/mux control bundle passed through.

- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-low reset; sampled on the `Clk` rising edge.
- `ID_Instruction`  in  32  raw instruction in ID.
- `ID_ReadData1`, `ID_ReadData2`  in  32 each  register file read data (rs, rt).
- `ID_Immediate`  in  32  sign/zero-extended immediate.
- `ID_PCPlus4`  in  32  PC+4 of the ID instruction.
- `ID_RegisterDestination`  in  32  destination register index, zero-extended from 5 bits.
- `ID_RegWrite`, `ID_MemRead`, `ID_MemWrite`  in  1 each  decoded control.
- `ID_Control`  in  CTRL_WIDTH  remaining control bundle.
- `BranchFlush`  in  1  squash the ID instruction; taken branch or jump resolved.
- `EX_Instruction`, `EX_ReadData1`, `EX_ReadData2`, `EX_Immediate`, `EX_PCPlus4`, `EX_RegisterDestination`  out  32 each  registered copies.
- `EX_RegWrite`, `EX_MemRead`, `EX_MemWrite`  out  1 each  registered control.
- `EX_Control`  out  CTRL_WIDTH  registered control bundle.
- `EX_Valid`  out  1  1 = real instruction in EX, 0 = bubble.
- `Stall`  out  1  combinational; 1 = hold PC and IF/ID this cycle.
- `StallCount`  out  32  count of load-use stall cycles (see Configuration).

## Operation
- ID fields: rs = `ID_Instruction[25:21]`, rt = `[20:16]`, opcode = `[31:26]`.
- rt is a source only when opcode ∈ {000000, 000100 beq, 000101 bne, 101011 sw, 101000 sb, 101001 sh}.
- `LoadUse` = `EX_MemRead` & `EX_Valid` & (`EX_RegisterDestination` ≠ 0) & ((`EX_RegisterDestination` == rs) | (rt is a source & `EX_RegisterDestination` == rt)). Compare against the zero-extended 32-bit index.
- `Stall` = `LoadUse` & ~`BranchFlush`.
- Priority at each rising edge:
  1. `Reset`=0: all EX outputs are set to 0.
  2. `BranchFlush`=1: bubble is loaded.
  3. `LoadUse`=1: bubble is loaded.
  4. Otherwise: all ID inputs are loaded and `EX_Valid` is set to 1.
- Bubble: `EX_Instruction`=0 (sll $0 nop), all EX data=0, `EX_RegisterDestination`=0, every control bit=0, `EX_Valid`=0.
- Reset values: every `EX_*` output 0, `EX_Valid` 0, `StallCount` 0. `Stall` is 0 because it derives from the cleared EX state.

## Timing
- Register latency is 1 cycle from ID inputs to EX outputs. `Stall` has 0-cycle combinational latency from ID inputs and EX state.
- A load-use hazard costs exactly one bubble:
  - Cycle N: load in EX, dependent in ID, `Stall`=1.
  - Edge N+1: bubble enters EX and the load moves to MEM.
  - Cycle N+1: `Stall`=0 because `EX_Valid`=0. The dependent enters EX at edge N+2; `ForwardingUnit` supplies the load data from WB.
- Back-to-back loads with a dependent: each load-use pair stalls once. There is no multi-cycle stall state.
- Simultaneous `BranchFlush` and `LoadUse`: flush wins, `Stall`=0, one bubble is inserted, and no stall is counted.
- A destination of $0 never stalls.
- Reset asserted mid-stall clears EX on that edge, so `Stall` drops in the next cycle.

## Configuration
- `ID_EX_STALL_COUNTER_EN` defined:
  - `StallCount` increments by 1 on each rising edge where `Reset`=1 and `Stall`=1.
  - It saturates at 0xFFFF_FFFF, clears on reset, and is held otherwise.
- `ID_EX_STALL_COUNTER_EN` undefined: the counter is not built and `StallCount` is tied to 0.

## Test plan
- Reset: drive `Reset`=0 for 2 cycles with all ID inputs 0xFFFF_FFFF -> all `EX_*`=0, `EX_Valid`=0, `Stall`=0, `StallCount`=0.
- Load-use on rs: `lw $8,0($9)` followed by `add $10,$8,$11`:
  - With lw in EX: `Stall`=1.
  - Next edge: `EX_Instruction`=0, `EX_RegWrite`=0, `EX_Valid`=0.
  - Next cycle: `Stall`=0. At the following edge, add is in EX with `EX_RegisterDestination`=10.
  - `StallCount`=1 with the macro defined.
- rt source vs dest: `lw $8` then `sw $8,0($9)` -> `Stall`=1. `lw $8` then `ori $8,$9,5` -> `Stall`=0 and ori is loaded directly.
- $0 and non-load: `lw $0,0($9)` then `add $10,$0,$0` -> `Stall`=0. `add $8,...` then `add $10,$8,$8` -> `Stall`=0.
- Flush priority: `lw $8` in EX, dependent `add $10,$8,$11` in ID, `BranchFlush`=1 -> `Stall`=0, bubble loaded, `StallCount` unchanged.
- Saturation (macro defined): force `StallCount` to 0xFFFF_FFFE, then run 3 stall cycles -> `StallCount`=0xFFFF_FFFF. With the macro undefined, `StallCount` stays 0 throughout.
